// File: rtl/mem_responder.sv
// mem_responder: byte-wide memory responder for a CPU memory controller.
// Every clock edge is one single-byte transaction. Addresses with
// bits [17:16] == 2'b11 reach the IO registers (UART TX FIFO, RX holding
// byte, halt port, status). All other addresses reach an internal RAM that
// is never cleared by reset, so contents preloaded at start-up survive it.
module mem_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_address_in,
  input  logic [7:0]  ram_data_in,
  input  logic        ram_rw_signal_in,
  output logic [7:0]  ram_data_out,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        io_buffer_full,
  output logic        halt_out,
  output logic [7:0]  halt_code_out,
  output logic [1:0]  err_out
);

  localparam int RAM_WORDS = 1 << RAM_ADDR_WIDTH;
  localparam int PTR_W     = $clog2(TX_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] HIWAT_C = CNT_W'(TX_DEPTH - 2);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR1_C  = PTR_W'(1);

  // Storage: RAM and TX FIFO slots carry no reset.
  logic [7:0] r_mem    [0:RAM_WORDS-1];
  logic [7:0] r_tx_mem [0:TX_DEPTH-1];

  // Registered state.
  logic [7:0]       r_ram_data_out;
  logic [PTR_W-1:0] r_tx_wptr;
  logic [PTR_W-1:0] r_tx_rptr;
  logic [CNT_W-1:0] r_tx_count;
  logic             r_io_buffer_full;
  logic             r_rx_full;
  logic [7:0]       r_rx_data;
  logic             r_halt;
  logic [7:0]       r_halt_code;
  logic [1:0]       r_err;

  // Decode and control wires.
  logic                      w_is_io;
  logic                      w_sel_data;
  logic                      w_sel_ctrl;
  logic [RAM_ADDR_WIDTH-1:0] w_ram_addr;
  logic                      w_tx_push_req;
  logic                      w_tx_pop;
  logic                      w_tx_full;
  logic                      w_tx_push;
  logic                      w_tx_overflow;
  logic [CNT_W-1:0]          w_tx_count_next;
  logic                      w_rx_read;
  logic                      w_rx_capture;
  logic                      w_rx_overrun;
  logic                      w_halt_wr;
  logic [7:0]                w_rd_next;
  logic                      w_unused;

  // Upper address bits carry no meaning for this responder.
  assign w_unused = ^ram_address_in[31:18];

  assign w_is_io    = (ram_address_in[17:16] == 2'b11);
  assign w_sel_data = w_is_io && (ram_address_in[15:0] == 16'h0000);
  assign w_sel_ctrl = w_is_io && (ram_address_in[15:0] == 16'h0004);
  assign w_ram_addr = ram_address_in[RAM_ADDR_WIDTH-1:0];

  // A full FIFO still takes a push when the sink drains a slot the same cycle.
  assign w_tx_push_req = w_sel_data && ram_rw_signal_in;
  assign w_tx_pop      = uart_tx_valid && uart_tx_ready;
  assign w_tx_full     = (r_tx_count == DEPTH_C);
  assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);
  assign w_tx_overflow = w_tx_push_req && w_tx_full && !w_tx_pop;

  // A CPU read of the RX byte frees the holder for an arriving byte.
  assign w_rx_read    = w_sel_data && !ram_rw_signal_in;
  assign w_rx_capture = uart_rx_valid && (!r_rx_full || w_rx_read);
  assign w_rx_overrun = uart_rx_valid && r_rx_full && !w_rx_read;

  assign w_halt_wr = w_sel_ctrl && ram_rw_signal_in && !r_halt;

  assign ram_data_out   = r_ram_data_out;
  assign uart_tx_valid  = (r_tx_count != {CNT_W{1'b0}});
  assign uart_tx_data   = r_tx_mem[r_tx_rptr];
  assign io_buffer_full = r_io_buffer_full;
  assign halt_out       = r_halt;
  assign halt_code_out  = r_halt_code;
  assign err_out        = r_err;

  // Next TX occupancy from the push/pop pair of this cycle.
  always_comb begin
    w_tx_count_next = r_tx_count;
    case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_count_next = r_tx_count + ONE_C;
      2'b01:   w_tx_count_next = r_tx_count - ONE_C;
      default: w_tx_count_next = r_tx_count;
    endcase
  end

  // Read-data mux: RAM byte, RX byte, status byte or zero.
  always_comb begin
    w_rd_next = 8'h00;
    if (!w_is_io) begin
      w_rd_next = r_mem[w_ram_addr];
    end else if (w_sel_data) begin
      w_rd_next = r_rx_full ? r_rx_data : 8'h00;
    end else if (w_sel_ctrl) begin
      w_rd_next = {5'b00000, r_halt, r_rx_full, ~uart_tx_valid};
    end else begin
      w_rd_next = 8'h00;
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_rw_signal_in && !w_is_io) begin
      r_mem[w_ram_addr] <= ram_data_in;
    end
  end

  // TX FIFO slot write; slots need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr] <= ram_data_in;
    end
  end

  // Registered read data: updated on every read, held across writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ram_data_out <= 8'h00;
    end else if (!ram_rw_signal_in) begin
      r_ram_data_out <= w_rd_next;
    end
  end

  // TX FIFO pointers, occupancy and the early backpressure hint.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wptr        <= {PTR_W{1'b0}};
      r_tx_rptr        <= {PTR_W{1'b0}};
      r_tx_count       <= {CNT_W{1'b0}};
      r_io_buffer_full <= 1'b0;
    end else begin
      if (w_tx_push) begin
        r_tx_wptr <= r_tx_wptr + PTR1_C;
      end
      if (w_tx_pop) begin
        r_tx_rptr <= r_tx_rptr + PTR1_C;
      end
      r_tx_count       <= w_tx_count_next;
      r_io_buffer_full <= (w_tx_count_next >= HIWAT_C);
    end
  end

  // RX holding register: capture, clear on read, or drop on overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_full <= 1'b0;
      r_rx_data <= 8'h00;
    end else if (w_rx_capture) begin
      r_rx_full <= 1'b1;
      r_rx_data <= uart_rx_data;
    end else if (w_rx_read) begin
      r_rx_full <= 1'b0;
      r_rx_data <= 8'h00;
    end
  end

  // Sticky halt flag: only the first halt-port write is recorded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halt      <= 1'b0;
      r_halt_code <= 8'h00;
    end else if (w_halt_wr) begin
      r_halt      <= 1'b1;
      r_halt_code <= ram_data_in;
    end
  end

  // Sticky error flags {rx_overrun, tx_overflow}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 2'b00;
    end else begin
      if (w_tx_overflow) begin
        r_err[0] <= 1'b1;
      end
      if (w_rx_overrun) begin
        r_err[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios plus randomized traffic, all checked
// against a queue/associative-array reference model of the responder.
module tb_mem_responder;

  localparam int TX_DEPTH = 8;
  localparam logic [31:0] IDLE_A = 32'h0003_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = IDLE_A;
  logic [7:0]  wdata = 8'h00;
  logic        rw = 1'b0;
  logic [7:0]  rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        buf_full;
  logic        halt;
  logic [7:0]  halt_code;
  logic [1:0]  err;

  mem_responder #(.RAM_ADDR_WIDTH(17), .TX_DEPTH(TX_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ram_address_in(addr), .ram_data_in(wdata), .ram_rw_signal_in(rw),
    .ram_data_out(rd_data),
    .uart_tx_data(tx_data), .uart_tx_valid(tx_valid), .uart_tx_ready(tx_ready),
    .uart_rx_data(rx_data), .uart_rx_valid(rx_valid),
    .io_buffer_full(buf_full), .halt_out(halt), .halt_code_out(halt_code),
    .err_out(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] ref_mem [int];
  logic [7:0] tx_q [$];
  logic       m_rx_full;
  logic [7:0] m_rx_data;
  logic       m_halt;
  logic [7:0] m_code;
  logic [1:0] m_err;
  logic [7:0] m_rd;
  logic       m_rd_known;
  logic       cur_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    m_rx_full  = 1'b0;
    m_rx_data  = 8'h00;
    m_halt     = 1'b0;
    m_code     = 8'h00;
    m_err      = 2'b00;
    m_rd       = 8'h00;
    m_rd_known = 1'b1;
  endtask

  // One transaction as described by the responder's rules.
  task automatic model_edge();
    logic        io;
    logic [15:0] off;
    logic        pop;
    logic        rx_read;
    logic [7:0]  status;
    int          key;
    io      = (addr[17:16] == 2'b11);
    off     = addr[15:0];
    pop     = (tx_q.size() != 0) && tx_ready;
    status  = {5'b00000, m_halt, m_rx_full, (tx_q.size() == 0)};
    rx_read = 1'b0;
    if (!io) begin
      key = int'(addr[16:0]);
      if (rw) ref_mem[key] = wdata;
      else if (ref_mem.exists(key)) begin m_rd = ref_mem[key]; m_rd_known = 1'b1; end
      else m_rd_known = 1'b0;
    end else if (!rw) begin
      m_rd_known = 1'b1;
      if (off == 16'h0000) begin
        m_rd = m_rx_full ? m_rx_data : 8'h00;
        rx_read = 1'b1;
      end else if (off == 16'h0004) m_rd = status;
      else m_rd = 8'h00;
    end
    if (pop) void'(tx_q.pop_front());
    if (io && rw && off == 16'h0000) begin
      if (tx_q.size() < TX_DEPTH) tx_q.push_back(wdata);
      else m_err[0] = 1'b1;
    end
    if (io && rw && off == 16'h0004 && !m_halt) begin
      m_halt = 1'b1;
      m_code = wdata;
    end
    if (rx_read) m_rx_full = 1'b0;
    if (rx_valid) begin
      if (!m_rx_full) begin m_rx_full = 1'b1; m_rx_data = rx_data; end
      else m_err[1] = 1'b1;
    end
  endtask

  task automatic compare_model();
    if (m_rd_known) check("rd_data", 32'(rd_data), 32'(m_rd));
    check("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
    if (tx_q.size() != 0) check("tx_data", 32'(tx_data), 32'(tx_q[0]));
    check("buf_full", 32'(buf_full), 32'(tx_q.size() >= TX_DEPTH - 2));
    check("halt", 32'(halt), 32'(m_halt));
    check("halt_code", 32'(halt_code), 32'(m_code));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic step(input logic [31:0] a, input logic [7:0] d, input logic w,
                      input logic rxv, input logic [7:0] rxd);
    addr = a; wdata = d; rw = w; tx_ready = cur_ready; rx_valid = rxv; rx_data = rxd;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    step(a, d, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a);
    step(a, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic idle_rx(input logic rxv, input logic [7:0] rxd);
    step(IDLE_A, 8'h00, 1'b0, rxv, rxd);
  endtask

  // Asserts reset between edges and checks outputs clear with no clock edge.
  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    model_reset();
    check("rst_rd", 32'(rd_data), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_code", 32'(halt_code), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_buf_full", 32'(buf_full), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] exp4 [4];
    int pops;
    logic [7:0] last;
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_reset();
    @(posedge clk);
    do_reset();

    // Sequential writes then slow reads.
    for (int i = 0; i < 4; i++) wr(32'h1000 + i, exp4[i]);
    for (int i = 0; i < 4; i++) begin
      rd(32'h1000 + i);
      check("ram_seq_first", 32'(rd_data), 32'(exp4[i]));
      rd(32'h1000 + i);
      check("ram_seq_hold", 32'(rd_data), 32'(exp4[i]));
    end

    // Read-after-write back to back.
    wr(32'h200, 8'hAB);
    rd(32'h200);
    check("raw", 32'(rd_data), 32'hAB);

    // TX overflow with sink stalled, then drain in order.
    cur_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr(32'h0003_0000, 8'(8'hC0 + i));
      if (i == 4) check("hint_before", 32'(buf_full), 32'h0);
      if (i == 5) check("hint_at6", 32'(buf_full), 32'h1);
      if (i == 7) check("no_ovf_at8", 32'(err), 32'h0);
    end
    check("ovf_flag", 32'(err), 32'h1);
    cur_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", 32'(tx_valid), 32'h1);
      check("drain_data", 32'(tx_data), 32'(8'hC0 + k));
      idle_rx(1'b0, 8'h00);
    end
    check("drain_empty", 32'(tx_valid), 32'h0);

    // Push into a full FIFO while it pops.
    do_reset();
    cur_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(32'h0003_0000, 8'(8'h50 + i));
    check("full_hint", 32'(buf_full), 32'h1);
    cur_ready = 1'b1;
    wr(32'h0003_0000, 8'h5A);
    check("full_push_no_ovf", 32'(err), 32'h0);
    pops = 0;
    last = 8'h00;
    while (tx_valid && pops < 20) begin
      last = tx_data;
      pops++;
      idle_rx(1'b0, 8'h00);
    end
    check("full_push_count", 32'(pops), 32'd8);
    check("full_push_last", 32'(last), 32'h5A);

    // RX holding register behaviour.
    idle_rx(1'b1, 8'h41);
    idle_rx(1'b1, 8'h42);
    check("rx_overrun", 32'(err[1]), 32'h1);
    rd(32'h0003_0000);
    check("rx_first", 32'(rd_data), 32'h41);
    rd(32'h0003_0000);
    check("rx_empty_read", 32'(rd_data), 32'h00);
    idle_rx(1'b1, 8'h44);
    step(32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h43);
    check("rx_read_old", 32'(rd_data), 32'h44);
    rd(32'h0003_0004);
    check("status_rx", 32'(rd_data), 32'h03);
    rd(32'h0003_0000);
    check("rx_new_held", 32'(rd_data), 32'h43);

    // Halt port, sticky code, then reset mid-stream.
    wr(32'h0003_0004, 8'h07);
    wr(32'h0003_0004, 8'h09);
    check("halt_set", 32'(halt), 32'h1);
    check("halt_code", 32'(halt_code), 32'h07);
    rd(32'h0003_0004);
    check("status_halt", 32'(rd_data), 32'h05);
    rd(32'h1002);
    check("ram_after_halt", 32'(rd_data), 32'h33);
    cur_ready = 1'b0;
    wr(32'h0003_0000, 8'h99);
    do_reset();
    rd(32'h1000);
    check("ram_kept", 32'(rd_data), 32'h11);

    // Randomized traffic.
    for (int i = 0; i < 16; i++) wr(32'h100 + i, 8'($urandom()));
    for (int i = 0; i < 600; i++) begin
      logic [31:0] hi;
      logic [31:0] pa;
      hi = $urandom() & 32'hFFFC_0000;
      pa = 32'h100 + $urandom_range(0, 15) + ($urandom_range(0, 1) << 17);
      cur_ready = ($urandom_range(0, 2) == 0);
      if (i == 300) do_reset();
      case ($urandom_range(0, 9))
        0, 1:    step(hi | pa, 8'($urandom()), 1'b1, $urandom_range(0, 3) == 0, 8'($urandom()));
        2, 3, 4: step(hi | pa, 8'h00, 1'b0, $urandom_range(0, 3) == 0, 8'($urandom()));
        5:       step(hi | 32'h0003_0000, 8'($urandom()), 1'b1, $urandom_range(0, 3) == 0, 8'($urandom()));
        6:       step(hi | 32'h0003_0000, 8'h00, 1'b0, $urandom_range(0, 3) == 0, 8'($urandom()));
        7:       step(hi | 32'h0003_0004, 8'h00, 1'b0, $urandom_range(0, 3) == 0, 8'($urandom()));
        8:       step(hi | 32'h0003_0004, 8'($urandom()), 1'b1, $urandom_range(0, 3) == 0, 8'($urandom()));
        default: step(hi | 32'h0003_0008, 8'($urandom()), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 8'($urandom()));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
